// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/busy/done handshake.
// Eight operations on two WIDTH-bit operands. Logic/arithmetic ops complete
// one edge after start; MUL is an iterative shift-add taking WIDTH edges.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high reset
//   start  - capture Ain/Bin/ALUop on this edge when not busy
//   Ain    - operand A
//   Bin    - operand B
//   ALUop  - operation select
//   out    - registered result, holds the last completed result
//   Z, N   - zero / negative flags for out
//   V      - signed overflow flag (ADD/SUB only)
//   busy   - high while a multiply is in progress
//   done   - one-cycle pulse when a new out/Z/N/V first appears
module alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [2:0]       ALUop,
    output logic [WIDTH-1:0] out,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW  = $clog2(WIDTH + 1);
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOTB = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             v_q, v_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] diff_c;
    logic [WIDTH-1:0] alu_res_c;
    logic             alu_v_c;
    logic [WIDTH-1:0] acc_step_c;

    assign sum_c  = Ain + Bin;
    assign diff_c = Ain - Bin;

    // Single-cycle result and overflow for the non-multiply operations.
    always_comb begin
        alu_res_c = '0;
        alu_v_c   = 1'b0;
        case (ALUop)
            OP_ADD: begin
                alu_res_c = sum_c;
                alu_v_c   = (Ain[MSB] == Bin[MSB]) && (sum_c[MSB] != Ain[MSB]);
            end
            OP_SUB: begin
                alu_res_c = diff_c;
                alu_v_c   = (Ain[MSB] != Bin[MSB]) && (diff_c[MSB] != Ain[MSB]);
            end
            OP_AND:  alu_res_c = Ain & Bin;
            OP_NOTB: alu_res_c = ~Bin;
            OP_OR:   alu_res_c = Ain | Bin;
            OP_XOR:  alu_res_c = Ain ^ Bin;
            OP_SHR:  alu_res_c = Bin >> 1;
            default: alu_res_c = '0;
        endcase
    end

    // One shift-add step: accumulate the shifted multiplicand when the
    // current multiplier bit is set.
    assign acc_step_c = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        z_d      = z_q;
        n_d      = n_q;
        v_d      = v_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ALUop == OP_MUL) begin
                        mcand_d  = Ain;
                        mplier_d = Bin;
                        acc_d    = '0;
                        cnt_d    = CW'(WIDTH);
                        busy_d   = 1'b1;
                        state_d  = MULT;
                    end else begin
                        out_d  = alu_res_c;
                        z_d    = (alu_res_c == '0);
                        n_d    = alu_res_c[MSB];
                        v_d    = alu_v_c;
                        done_d = 1'b1;
                    end
                end
            end
            MULT: begin
                // start is ignored here; the in-flight multiply owns the unit.
                acc_d    = acc_step_c;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    out_d   = acc_step_c;
                    z_d     = (acc_step_c == '0);
                    n_d     = acc_step_c[MSB];
                    v_d     = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            out_q    <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out  = out_q;
    assign Z    = z_q;
    assign N    = n_q;
    assign V    = v_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a WIDTH=16 instance checked every cycle against a
// behavioural model, plus directed literal checks on it and on a WIDTH=8 instance.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start16;
    logic [15:0] a16, b16;
    logic [2:0]  op16;
    logic [15:0] out16;
    logic        z16, n16, v16, busy16, done16;

    logic        start8;
    logic [7:0]  a8, b8;
    logic [2:0]  op8;
    logic [7:0]  out8;
    logic        z8, n8, v8, busy8, done8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16),
        .Ain(a16), .Bin(b16), .ALUop(op16),
        .out(out16), .Z(z16), .N(n16), .V(v16), .busy(busy16), .done(done16)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8),
        .Ain(a8), .Bin(b8), .ALUop(op8),
        .out(out8), .Z(z8), .N(n8), .V(v8), .busy(busy8), .done(done8)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Result and signed-overflow flag from plain integer arithmetic.
    function automatic void ref_op(input int w, input int op, input longint a, input longint b,
                                   output longint r, output bit v);
        longint m, half, sa, sb, s;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa   = (a >= half) ? a - (longint'(1) << w) : a;
        sb   = (b >= half) ? b - (longint'(1) << w) : b;
        v    = 1'b0;
        r    = 0;
        case (op)
            0: begin s = sa + sb; v = (s > half - 1) || (s < -half); r = (a + b) & m; end
            1: begin s = sa - sb; v = (s > half - 1) || (s < -half); r = (a - b) & m; end
            2: r = a & b;
            3: r = (~b) & m;
            4: r = a | b;
            5: r = a ^ b;
            6: r = (a * b) & m;
            default: r = b / 2;
        endcase
    endfunction

    // Behavioural model of the 16-bit instance.
    longint m_out = 0, m_pend = 0;
    bit     m_z = 0, m_n = 0, m_v = 0, m_busy = 0, m_done = 0, started = 0;
    int     m_rem = 0;

    always @(posedge clk) begin
        longint r;
        bit     v;
        if (reset) begin
            m_out = 0; m_z = 0; m_n = 0; m_v = 0; m_busy = 0; m_done = 0; m_rem = 0;
            started = 1;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 0; m_done = 1;
                    m_out = m_pend; m_z = (m_pend == 0); m_n = m_pend[15]; m_v = 0;
                end
            end else if (start16) begin
                ref_op(16, int'(op16), longint'(a16), longint'(b16), r, v);
                if (op16 == 3'd6) begin
                    m_busy = 1; m_rem = 16; m_pend = r;
                end else begin
                    m_done = 1; m_out = r; m_z = (r == 0); m_n = r[15]; m_v = v;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_out",  64'(out16),  64'(m_out));
            chk("m_Z",    64'(z16),    64'(m_z));
            chk("m_N",    64'(n16),    64'(m_n));
            chk("m_V",    64'(v16),    64'(m_v));
            chk("m_busy", 64'(busy16), 64'(m_busy));
            chk("m_done", 64'(done16), 64'(m_done));
        end
    end

    task automatic go16(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start16 = 1'b1; op16 = o; a16 = a; b16 = b;
        @(posedge clk);
        #1 start16 = 1'b0;
    endtask

    task automatic go8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start8 = 1'b1; op8 = o; a8 = a; b8 = b;
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    // Count busy cycles until done; optionally poke start/inputs mid-multiply.
    task automatic wait_done16(input bit poke, output int nb, output bit got);
        nb = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done16) got = 1;
            else begin
                if (busy16) nb++;
                if (poke && i == 3) begin
                    start16 = 1'b1; op16 = 3'd0; a16 = 16'h0001; b16 = 16'h0001;
                end else if (poke && i == 4) begin
                    start16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nb, extra;
        bit  got;
        logic [15:0] r16;
        start16 = 0; a16 = 0; b16 = 0; op16 = 0;
        start8 = 0;  a8 = 0;  b8 = 0;  op8 = 0;
        repeat (2) @(negedge clk);
        chk("rst_out",  64'(out16), 64'h0);
        chk("rst_busy", 64'(busy16), 64'h0);
        chk("rst_done", 64'(done16), 64'h0);
        chk("rst_out8", 64'(out8), 64'h0);
        reset = 1'b0;

        // ADD overflow into the sign bit.
        go16(3'd0, 16'h7FFF, 16'h0001);
        @(negedge clk);
        chk("add_out", 64'(out16), 64'h8000);
        chk("add_N", 64'(n16), 64'h1);
        chk("add_V", 64'(v16), 64'h1);
        chk("add_Z", 64'(z16), 64'h0);
        chk("add_done", 64'(done16), 64'h1);
        chk("add_busy", 64'(busy16), 64'h0);
        @(negedge clk);
        chk("add_done_pulse", 64'(done16), 64'h0);

        // Back-to-back SUBs.
        @(negedge clk);
        start16 = 1'b1; op16 = 3'd1; a16 = 16'h0005; b16 = 16'h0005;
        @(posedge clk);
        #1 a16 = 16'h8000; b16 = 16'h0001;
        @(negedge clk);
        chk("sub1_out", 64'(out16), 64'h0);
        chk("sub1_Z", 64'(z16), 64'h1);
        chk("sub1_V", 64'(v16), 64'h0);
        chk("sub1_done", 64'(done16), 64'h1);
        @(posedge clk);
        #1 start16 = 1'b0;
        @(negedge clk);
        chk("sub2_out", 64'(out16), 64'h7FFF);
        chk("sub2_N", 64'(n16), 64'h0);
        chk("sub2_V", 64'(v16), 64'h1);
        chk("sub2_done", 64'(done16), 64'h1);
        @(negedge clk);
        chk("sub2_done_pulse", 64'(done16), 64'h0);

        // MUL with an ignored start mid-flight.
        go16(3'd6, 16'h0123, 16'h0010);
        wait_done16(1'b1, nb, got);
        chk("mul1_seen", 64'(got), 64'h1);
        chk("mul1_busy_cycles", 64'(nb), 64'd16);
        chk("mul1_out", 64'(out16), 64'h1230);
        chk("mul1_busy_end", 64'(busy16), 64'h0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (done16) extra++;
        end
        chk("mul1_no_extra_done", 64'(extra), 64'h0);

        go16(3'd6, 16'h0100, 16'h0100);
        wait_done16(1'b0, nb, got);
        chk("mul2_seen", 64'(got), 64'h1);
        chk("mul2_out", 64'(out16), 64'h0);
        chk("mul2_Z", 64'(z16), 64'h1);
        chk("mul2_V", 64'(v16), 64'h0);

        // Reset aborts a multiply.
        go16(3'd0, 16'h1234, 16'h1111);
        go16(3'd6, 16'h00FF, 16'h00FF);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy16), 64'h0);
        chk("abort_out", 64'(out16), 64'h0);
        chk("abort_ZNV", 64'({z16, n16, v16}), 64'h0);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done16) extra++;
        end
        chk("abort_no_done", 64'(extra), 64'h0);
        go16(3'd0, 16'h0002, 16'h0003);
        @(negedge clk);
        chk("post_abort_add", 64'(out16), 64'h5);
        chk("post_abort_done", 64'(done16), 64'h1);

        // Randomised traffic, checked by the model every cycle.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            reset   = ($urandom_range(0, 99) == 0);
            start16 = $urandom_range(0, 1);
            op16    = 3'($urandom_range(0, 7));
            a16     = 16'($urandom);
            b16     = 16'($urandom);
        end
        @(negedge clk);
        reset = 1'b0; start16 = 1'b0;
        repeat (20) @(negedge clk);

        // Model self-check against a hand-computed value.
        go16(3'd6, 16'h0003, 16'h0007);
        wait_done16(1'b0, nb, got);
        r16 = out16;
        chk("mul_3x7", 64'(r16), 64'd21);

        // 8-bit instance.
        go8(3'd0, 8'hFF, 8'h01);
        @(negedge clk);
        chk("w8_add_out", 64'(out8), 64'h00);
        chk("w8_add_Z", 64'(z8), 64'h1);
        chk("w8_add_V", 64'(v8), 64'h0);
        chk("w8_add_done", 64'(done8), 64'h1);
        go8(3'd7, 8'h00, 8'h81);
        @(negedge clk);
        chk("w8_shr_out", 64'(out8), 64'h40);
        chk("w8_shr_N", 64'(n8), 64'h0);
        go8(3'd3, 8'h00, 8'h0F);
        @(negedge clk);
        chk("w8_notb_out", 64'(out8), 64'hF0);
        chk("w8_notb_N", 64'(n8), 64'h1);
        go8(3'd6, 8'h0F, 8'h11);
        nb = 0; got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (done8) got = 1;
            else if (busy8) nb++;
        end
        chk("w8_mul_seen", 64'(got), 64'h1);
        chk("w8_mul_busy_cycles", 64'(nb), 64'd8);
        chk("w8_mul_out", 64'(out8), 64'hFF);
        chk("w8_mul_N", 64'(n8), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
